bf16_mul_frontend: RTL and testbench
====================================

BF16_MUL_FRONTEND -- requirements
Module: bf16_mul_frontend

Interface
REQ-001 SHALL have parameter EXP_BIAS, default 127, the exponent bias subtracted from the summed operand exponents.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a_bf16/b_bf16 is valid.
REQ-005 SHALL have port in_ready  output  1  block accepts the pair this cycle.
REQ-006 SHALL have port a_bf16  input  16  operand A, bf16 format {sign, exp[7:0], frac[6:0]}.
REQ-007 SHALL have port b_bf16  input  16  operand B, bf16 format.
REQ-008 SHALL have port out_valid  output  1  result fields are valid.
REQ-009 SHALL have port out_ready  input  1  downstream normalizer consumes the result this cycle.
REQ-010 SHALL have port sign  output  1  product sign.
REQ-011 SHALL have port exp_out  output  9  biased product exponent before normalization.
REQ-012 SHALL have port mant_raw  output  16  raw 8x8 product of the hidden-bit significands.
REQ-013 SHALL have port nan_out  output  1  result is NaN.

Function
REQ-014 SHALL accept an input on a cycle with in_valid && in_ready; SHALL deliver an output on a cycle with out_valid && out_ready.
REQ-015 SHALL implement a 2-stage pipeline: S1 registers unpack, classification and exponent sum; S2 registers the product and the final fields.
REQ-016 SHALL have a latency of 2 cycles from acceptance to out_valid when out_ready is held high, with a throughput of 1 result per cycle.
REQ-017 SHALL advance each stage only when that stage's downstream slot is empty or is being consumed in the same cycle; in_ready = !s1_valid || (the S1 contents move to S2 this cycle).
REQ-018 SHALL hold sign, exp_out, mant_raw and nan_out stable while out_valid && !out_ready.
REQ-019 SHALL never drop or duplicate a result; at most 2 results are in flight.
REQ-020 SHALL compute sign = a[15] XOR b[15] in all cases, including zero, inf and NaN.
REQ-021 SHALL classify each operand as follows: exp==0 is zero (subnormals flushed to zero); exp==0xFF with frac==0 is inf; exp==0xFF with frac!=0 is NaN; all other values are normal.
REQ-022 SHALL, for normal x normal, set mant_raw = {1,fracA} * {1,fracB} as a 16-bit unsigned value, and set esum = expA + expB as a 9-bit value.
REQ-023 SHALL, for normal x normal with esum <= EXP_BIAS (underflow), output exp_out = 0 and mant_raw = 0.
REQ-024 SHALL, for normal x normal with esum - EXP_BIAS >= 255 (overflow), output exp_out = 9'h0FF and mant_raw = 16'h4000.
REQ-025 SHALL, for normal x normal otherwise, output exp_out = esum - EXP_BIAS, in the range 1..254.
REQ-026 SHALL, when either operand is NaN, or for inf x zero, output nan_out = 1, exp_out = 9'h0FF and mant_raw = 16'h6000.
REQ-027 SHALL, for inf x (inf or normal), output nan_out = 0, exp_out = 9'h0FF and mant_raw = 16'h4000.
REQ-028 SHALL, for zero x (zero or normal), output exp_out = 0, mant_raw = 0 and nan_out = 0.
REQ-029 SHALL apply special-case precedence in this order: NaN, inf x zero, inf, zero, underflow/overflow, normal.
REQ-030 SHALL, when an acceptance and a delivery occur in the same cycle with the pipeline full, accept the new input without a bubble.

Reset
REQ-031 SHALL, while rst_n is low at a clock edge, clear s1_valid and out_valid to 0, and clear sign, exp_out, mant_raw and nan_out to 0.
REQ-032 SHALL drive in_ready = 0 during reset and in_ready = 1 in the first cycle after reset is released.
REQ-033 SHALL discard any in-flight results on a reset asserted mid-operation; no out_valid is produced for inputs accepted before the reset.

Verification
REQ-034 SHALL cover: 0x3F80 x 0x3F80 with out_ready=1 -> 2 cycles later out_valid=1, sign=0, exp_out=0x07F, mant_raw=0x4000.
REQ-035 SHALL cover: 0x4000 x 0x4040 (2.0 x 3.0) -> sign=0, exp_out=0x081, mant_raw=0x6000; and 0xBFC0 x 0x3FC0 -> sign=1, exp_out=0x07F, mant_raw=0x9000.
REQ-036 SHALL cover: 0x0000 x 0x4000 -> exp_out=0, mant_raw=0; 0x7F80 x 0x0000 -> nan_out=1, exp_out=0x0FF, mant_raw=0x6000; 0x7F00 x 0x7F00 -> exp_out=0x0FF, mant_raw=0x4000.
REQ-037 SHALL cover: 0x0080 x 0x0080 (esum=2) -> exp_out=0, mant_raw=0.
REQ-038 SHALL cover backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready=0 after 2 acceptances, the first result held stable, then all 4 results delivered in order once out_ready=1.
REQ-039 SHALL cover reset mid-operation: rst_n=0 for 1 cycle with 2 results in flight -> out_valid=0 next cycle, in_ready=1 after release, no stale result ever emitted.

Source files
------------

// File: rtl/bf16_mul_frontend.sv
// bf16 multiplier front end: unpack/classify operands, form the raw significand
// product and the biased exponent, ahead of a separate normalizer stage.
module bf16_mul_frontend #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_bf16,
  input  logic [15:0] b_bf16,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [8:0]  exp_out,
  output logic [15:0] mant_raw,
  output logic        nan_out
);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  function automatic cls_t classify(input logic [7:0] e, input logic [6:0] f);
    if (e == 8'h00)      return CLS_ZERO;
    else if (e == 8'hFF) return (f == 7'd0) ? CLS_INF : CLS_NAN;
    else                 return CLS_NORM;
  endfunction

  // Folds both operand classes into one product class, NaN first, then inf x zero.
  function automatic cls_t combine(input cls_t ca, input cls_t cb);
    if (ca == CLS_NAN || cb == CLS_NAN)                             return CLS_NAN;
    if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) return CLS_NAN;
    if (ca == CLS_INF || cb == CLS_INF)                             return CLS_INF;
    if (ca == CLS_ZERO || cb == CLS_ZERO)                           return CLS_ZERO;
    return CLS_NORM;
  endfunction

  // Returns {nan, exp[8:0], mant[15:0]}; rebias with underflow/overflow saturation.
  function automatic logic [25:0] resolve(input cls_t c, input logic [8:0] esum,
                                          input logic [15:0] prod);
    logic signed [10:0] e_unb;
    e_unb = $signed({2'b00, esum}) - $signed(11'(EXP_BIAS));
    case (c)
      CLS_NAN:  return {1'b1, 9'h0FF, 16'h6000};
      CLS_INF:  return {1'b0, 9'h0FF, 16'h4000};
      CLS_ZERO: return {1'b0, 9'h000, 16'h0000};
      default: begin
        if (e_unb <= 11'sd0)        return {1'b0, 9'h000, 16'h0000};
        else if (e_unb >= 11'sd255) return {1'b0, 9'h0FF, 16'h4000};
        else                        return {1'b0, e_unb[8:0], prod};
      end
    endcase
  endfunction

  logic        r_vld_p1;
  logic        r_sign_p1;
  cls_t        r_cls_p1;
  logic [8:0]  r_esum_p1;
  logic [7:0]  r_sig_a_p1;
  logic [7:0]  r_sig_b_p1;

  logic        r_vld_p2;
  logic        r_sign_p2;
  logic [8:0]  r_exp_p2;
  logic [15:0] r_mant_p2;
  logic        r_nan_p2;

  logic        w_adv_p2;
  logic        w_take_p0;
  cls_t        w_cls_p0;
  logic [8:0]  w_esum_p0;
  logic [15:0] w_prod_p1;
  logic [25:0] w_res_p1;

  assign w_adv_p2  = !r_vld_p2 || out_ready;
  assign in_ready  = rst_n && (!r_vld_p1 || w_adv_p2);
  assign w_take_p0 = in_valid && in_ready;

  assign w_cls_p0  = combine(classify(a_bf16[14:7], a_bf16[6:0]),
                             classify(b_bf16[14:7], b_bf16[6:0]));
  assign w_esum_p0 = {1'b0, a_bf16[14:7]} + {1'b0, b_bf16[14:7]};

  // ---- stage 1: unpack, classify, exponent sum ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_take_p0) begin
      r_sign_p1  <= a_bf16[15] ^ b_bf16[15];
      r_cls_p1   <= w_cls_p0;
      r_esum_p1  <= w_esum_p0;
      r_sig_a_p1 <= {1'b1, a_bf16[6:0]};
      r_sig_b_p1 <= {1'b1, b_bf16[6:0]};
    end
  end

  assign w_prod_p1 = {8'h00, r_sig_a_p1} * {8'h00, r_sig_b_p1};
  assign w_res_p1  = resolve(r_cls_p1, r_esum_p1, w_prod_p1);

  // ---- stage 2: product and final fields ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_sign_p2 <= 1'b0;
      r_exp_p2  <= 9'h000;
      r_mant_p2 <= 16'h0000;
      r_nan_p2  <= 1'b0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sign_p2 <= r_sign_p1;
        r_nan_p2  <= w_res_p1[25];
        r_exp_p2  <= w_res_p1[24:16];
        r_mant_p2 <= w_res_p1[15:0];
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign sign      = r_sign_p2;
  assign exp_out   = r_exp_p2;
  assign mant_raw  = r_mant_p2;
  assign nan_out   = r_nan_p2;

endmodule

// File: tb/tb_bf16_mul_frontend.sv
// Randomized and directed bench for bf16_mul_frontend with a behavioural
// product model and an in-order scoreboard.
module tb_bf16_mul_frontend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_bf16;
  logic [15:0] b_bf16;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [8:0]  exp_out;
  logic [15:0] mant_raw;
  logic        nan_out;

  bf16_mul_frontend #(.EXP_BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_bf16(a_bf16), .b_bf16(b_bf16), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp_out(exp_out), .mant_raw(mant_raw), .nan_out(nan_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic        chk_lat   = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] held_val;
  logic        acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Model: {sign, nan, exp[8:0], mant[15:0]} from the value-level rules.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, e;
    bit s, za, zb, ia, ib, na, nb;
    s  = a[15] ^ b[15];
    ea = int'(a[14:7]); eb = int'(b[14:7]);
    fa = int'(a[6:0]);  fb = int'(b[6:0]);
    za = (ea == 0);  zb = (eb == 0);
    ia = (ea == 255 && fa == 0); ib = (eb == 255 && fb == 0);
    na = (ea == 255 && fa != 0); nb = (eb == 255 && fb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {5'd0, s, 1'b1, 9'h0FF, 16'h6000};
    if (ia || ib)                             return {5'd0, s, 1'b0, 9'h0FF, 16'h4000};
    if (za || zb)                             return {5'd0, s, 1'b0, 9'h000, 16'h0000};
    e = ea + eb - 127;
    if (e <= 0)   return {5'd0, s, 1'b0, 9'h000, 16'h0000};
    if (e >= 255) return {5'd0, s, 1'b0, 9'h0FF, 16'h4000};
    return {5'd0, s, 1'b0, 9'(e), 16'((128 + fa) * (128 + fb))};
  endfunction

  function automatic logic [31:0] dut_out();
    return {5'd0, sign, nan_out, exp_out, mant_raw};
  endfunction

  // One clock cycle: drive at negedge, observe handshakes shortly after.
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic ordy, output logic accepted);
    logic [31:0] e;
    int t;
    @(negedge clk);
    in_valid = iv; a_bf16 = a; b_bf16 = b; out_ready = ordy;
    #1;
    cyc++;
    accepted = 1'b0;
    if (rst_n) begin
      if (hold_prev) chk("hold", dut_out(), held_val);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          t = lat_q.pop_front();
          chk("result", dut_out(), e);
          if (chk_lat) chk("latency", 32'(cyc - t), 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(a, b));
        lat_q.push_back(cyc);
        accepted = 1'b1;
      end
      hold_prev = out_valid && !out_ready;
      held_val  = dut_out();
    end else begin
      hold_prev = 1'b0;
    end
  endtask

  task automatic drain();
    logic dummy;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 1'b1, dummy);
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) step(1'b1, a, b, 1'b1, got);
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    drain();
  endtask

  function automatic logic [15:0] rnd_op();
    logic [7:0] e;
    logic [6:0] f;
    case ($urandom_range(0, 5))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(100, 155));
      default: e = 8'($urandom_range(0, 255));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(0, 127));
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  initial begin
    logic [15:0] bp_a[4];
    int idx, nacc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_bf16 = '0; b_bf16 = '0;

    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", dut_out(), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Directed cases
    chk_lat = 1'b1;
    send(16'h3F80, 16'h3F80);
    chk_lat = 1'b0;
    send(16'h4000, 16'h4040);
    send(16'hBFC0, 16'h3FC0);
    send(16'h0000, 16'h4000);
    send(16'h7F80, 16'h0000);
    send(16'h7F00, 16'h7F00);
    send(16'h0080, 16'h0080);
    send(16'hFFC1, 16'h3F80);
    send(16'h7F80, 16'hC000);

    // Backpressure: four back-to-back inputs, downstream stalled 5 cycles
    bp_a[0] = 16'h3F80; bp_a[1] = 16'h4000; bp_a[2] = 16'hC040; bp_a[3] = 16'h4100;
    idx = 0; nacc = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, bp_a[idx], 16'h3FC0, 1'b0, acc);
      if (acc) begin idx++; nacc++; end
    end
    chk("bp_accepts", 32'(nacc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 20 && idx < 4; i++) begin
      step(1'b1, bp_a[idx], 16'h3FC0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_all_sent", 32'(idx), 32'd4);
    drain();

    // Reset with two results in flight
    step(1'b1, 16'h4000, 16'h4000, 1'b0, acc);
    step(1'b1, 16'h4040, 16'h4000, 1'b0, acc);
    step(1'b0, 16'h0, 16'h0, 1'b0, acc);
    chk("inflight_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete(); lat_q.delete();
    rst_n = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready1", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 16'h0, 1'b1, acc);

    // Random traffic with random backpressure
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_op(), rnd_op(),
           1'($urandom_range(0, 9) < 7), acc);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
